scan_cfg_loader: RTL and testbench
==================================

Name: scan_cfg_loader

Overview:
- Host-side driver for the CLB configuration scan chain. It is the transmitting end of the chain's scan_clk, scan_en and scan_in protocol.
- Accepts configuration words over a valid/ready stream and serializes exactly CHAIN_LEN bits into the chain on a register-generated scan_clk.
- Captures the bits falling out of scan_out as readback words.
- Sits between the bitstream source (host/ROM) and the first CLB of the chain.

Parameters:
- WORD_W, 8: width of input and readback words.
- CHAIN_LEN, 29: total scan bits in the chain. 29 = 1 is_comb bit + 12 conn-select bits + 16 LUT bits for the default CLB.
- DIV, 1: clk cycles per scan_clk phase (low and high each last DIV cycles); must be >= 1.
- CNT_W, 16: width of the bit counter; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- start  in  1  single-cycle pulse that begins a load pass; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive.
- done  out  1  single-cycle pulse when a pass completes.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word (high only in LOAD state).
- in_data  in  WORD_W  configuration word; shifted LSB first.
- scan_clk  out  1  scan clock to the chain, driven directly from a flop.
- scan_en  out  1  scan enable to the chain.
- scan_in  out  1  serial data to the chain head.
- scan_out  in  1  serial data from the chain tail.
- rb_valid  out  1  single-cycle pulse when a readback word is ready.
- rb_data  out  WORD_W  readback word; holds its value between pulses.

Behaviour:
- Reset values: scan_clk=0, scan_en=0, scan_in=0, busy=0, done=0, in_ready=0, rb_valid=0, rb_data=0. State = IDLE; all counters = 0.
- IDLE:
  - start=1 → LOAD next cycle; busy=1.
- LOAD:
  - in_ready=1 and scan_clk held 0.
  - On in_valid&in_ready: latch in_data into shift word, clear word bit index → LOW.
  - in_valid low stalls indefinitely; no scan_clk edges are produced while stalled.
- LOW (DIV cycles):
  - scan_en=1, scan_clk=0, scan_in = current bit of the latched word.
  - On the last LOW cycle, sample scan_out into the readback shift register at the current bit position → HIGH.
- HIGH (DIV cycles):
  - scan_clk=1; scan_in and scan_en are held stable.
  - At the end of HIGH: increment total and word-bit counters, then branch:
    - total == CHAIN_LEN → DONE.
    - else word bit index == WORD_W → LOAD.
    - else → LOW.
- DONE (1 cycle):
  - done=1, scan_clk=0, scan_en=0, scan_in=0 → IDLE; busy drops the next cycle.
- scan_en timing: scan_en rises with the first LOW cycle and stays 1 through every LOAD stall until DONE.
- Word count per pass: ceil(CHAIN_LEN/WORD_W) words are consumed.
  - Only the low (CHAIN_LEN mod WORD_W) bits of the final word are shifted; when the remainder is 0, all WORD_W bits are shifted.
  - Surplus high bits are discarded, and no extra word is requested.
- Edge ordering: the chain shifts on posedge scan_clk. scan_in is stable for DIV cycles before and DIV cycles after each rising edge.
- Readback:
  - Bit k of a pass is the scan_out value sampled before the k-th rising edge, i.e. the old chain content.
  - Bits are packed LSB first. rb_valid pulses for 1 cycle when WORD_W bits have been gathered or after the final bit.
  - The final partial word is zero-padded in its high bits.
  - There is no readback backpressure.
- Throughput: each bit takes 2*DIV clk cycles. Each word adds at least 1 LOAD cycle.
- start while busy: ignored, with no effect on counters.
- Reset mid-pass: all outputs return to reset values on the next edge, and no further scan_clk edges are generated. The chain contents are then undefined; a new start performs a full CHAIN_LEN pass.
- No combinational path from any input to scan_clk, scan_en or scan_in.

Test Plan:
1. Reset: assert reset for 3 cycles → every output 0, in_ready=0. Pulse start with reset high → no state change.
2. Load (DIV=1, WORD_W=8, CHAIN_LEN=29): send words 0xA5, 0x3C, 0xFF, 0x12 with in_valid always high.
   - Required: exactly 29 scan_clk rising edges, and scan_in shows 1,0,1,0,0,1,0,1 for the first byte.
   - The last word shifts only bits 0,1,0,0,1; 4 in_ready handshakes occur; done pulses once.
   - A chained CLB model then holds the loaded contents.
3. Readback: repeat the pass with the same data → rb_data pulses 0xA5, 0x3C, 0xFF, 0x12 (last word masked to 5 bits, i.e. 0x12).
4. Underrun: drop in_valid for 10 cycles before word 3 → scan_clk stays 0 and scan_en stays 1 for the stall. The total edge count is still 29 and the data matches scenario 2.
5. Reset mid-pass: assert reset after the 10th rising edge → scan_clk, scan_en and busy are 0 the next cycle with no further edges. A restart produces 29 edges.
6. DIV=3, plus a start pulse issued while busy → each scan_clk phase lasts 3 cycles; the second start is ignored and done pulses exactly once.

Source files
------------

// File: rtl/scan_cfg_loader.sv
// Host-side driver for the CLB configuration scan chain: serializes CHAIN_LEN bits
// from a word stream onto a flop-driven scan_clk and gathers the old chain contents as readback words.
module scan_cfg_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 29,
    parameter int DIV       = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              scan_clk,
    output logic              scan_en,
    output logic              scan_in,
    input  logic              scan_out,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);
    localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(DIV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] shift_word;
    logic [WORD_W-1:0] rb_shift;
    logic [WB_W-1:0]   wbit;
    logic [CNT_W-1:0]  total;
    logic [PH_W-1:0]   phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_word <= '0;
            rb_shift   <= '0;
            wbit       <= '0;
            total      <= '0;
            phase      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
            scan_clk   <= 1'b0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
            rb_valid   <= 1'b0;
            rb_data    <= '0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        total    <= '0;
                    end
                end
                LOAD: begin
                    // in_ready is high for the whole of LOAD, so in_valid alone completes the handshake
                    if (in_valid) begin
                        scan_in    <= in_data[0];
                        shift_word <= in_data >> 1;
                        scan_en    <= 1'b1;
                        in_ready   <= 1'b0;
                        wbit       <= '0;
                        phase      <= '0;
                        rb_shift   <= '0;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    if (phase == LAST_PH) begin
                        // scan_out still shows the pre-edge chain content here
                        for (int i = 0; i < WORD_W; i++)
                            if (wbit == WB_W'(i)) rb_shift[i] <= scan_out;
                        scan_clk <= 1'b1;
                        phase    <= '0;
                        state    <= HIGH;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                HIGH: begin
                    if (phase == LAST_PH) begin
                        scan_clk <= 1'b0;
                        phase    <= '0;
                        total    <= total + CNT_W'(1);
                        wbit     <= wbit + WB_W'(1);
                        if (total == LAST_BIT) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            scan_en  <= 1'b0;
                            scan_in  <= 1'b0;
                            rb_valid <= 1'b1;
                            rb_data  <= rb_shift;
                        end else if (wbit == LAST_WBIT) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                            rb_valid <= 1'b1;
                            rb_data  <= rb_shift;
                        end else begin
                            state      <= LOW;
                            scan_in    <= shift_word[0];
                            shift_word <= shift_word >> 1;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    total <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_cfg_loader.sv
// Directed bench: two loaders (DIV=1 and DIV=3), each feeding its own chained CLB shift-register model.
module tb_scan_cfg_loader;
    localparam int LIM = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0]      start, in_valid, busy, done, in_ready;
    logic [1:0]      scan_clk, scan_en, scan_in, scan_out, rb_valid;
    logic [1:0][7:0] in_data, rb_data;
    logic [7:0]      words [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h12};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    scan_cfg_loader #(.WORD_W(8), .CHAIN_LEN(29), .DIV(1), .CNT_W(16)) dut_d1 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .scan_clk(scan_clk[0]), .scan_en(scan_en[0]), .scan_in(scan_in[0]),
        .scan_out(scan_out[0]), .rb_valid(rb_valid[0]), .rb_data(rb_data[0])
    );

    scan_cfg_loader #(.WORD_W(8), .CHAIN_LEN(29), .DIV(3), .CNT_W(16)) dut_d3 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .scan_clk(scan_clk[1]), .scan_en(scan_en[1]), .scan_in(scan_in[1]),
        .scan_out(scan_out[1]), .rb_valid(rb_valid[1]), .rb_data(rb_data[1])
    );

    // Chain models: head at bit 28, tail (scan_out) at bit 0
    logic [28:0] chain0 = '0;
    logic [28:0] chain1 = '0;
    always @(posedge scan_clk[0]) if (scan_en[0]) chain0 <= {scan_in[0], chain0[28:1]};
    always @(posedge scan_clk[1]) if (scan_en[1]) chain1 <= {scan_in[1], chain1[28:1]};
    assign scan_out = {chain1[0], chain0[0]};

    int edges0 = 0, hs0 = 0, dn0 = 0, rbn0 = 0, bc0 = 0;
    logic [63:0] si0  = '0;
    logic [31:0] rbl0 = '0;
    always @(posedge scan_clk[0]) begin
        edges0 <= edges0 + 1;
        si0    <= {scan_in[0], si0[63:1]};
    end
    always @(posedge clk) begin
        if (in_valid[0] && in_ready[0]) hs0 <= hs0 + 1;
        if (done[0]) dn0 <= dn0 + 1;
        if (busy[0]) bc0 <= bc0 + 1;
        if (rb_valid[0]) begin
            rbn0 <= rbn0 + 1;
            rbl0 <= {rbl0[23:0], rb_data[0]};
        end
    end

    int edges1 = 0, hs1 = 0, dn1 = 0, bc1 = 0;
    int hrun1 = 0, lrun1 = 0, hmin1 = 99, hmax1 = 0, lmin1 = 99;
    always @(posedge scan_clk[1]) edges1 <= edges1 + 1;
    always @(posedge clk) begin
        if (in_valid[1] && in_ready[1]) hs1 <= hs1 + 1;
        if (done[1]) dn1 <= dn1 + 1;
        if (busy[1]) bc1 <= bc1 + 1;
        if (scan_clk[1]) begin
            hrun1 <= hrun1 + 1;
            if (lrun1 != 0 && lrun1 < lmin1) lmin1 <= lrun1;
            lrun1 <= 0;
        end else begin
            if (hrun1 != 0) begin
                if (hrun1 < hmin1) hmin1 <= hrun1;
                if (hrun1 > hmax1) hmax1 <= hrun1;
            end
            hrun1 <= 0;
            lrun1 <= scan_en[1] ? lrun1 + 1 : 0;
        end
    end

    function automatic int edges_of(input int d);
        return (d != 0) ? edges1 : edges0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full pass on loader d; optional 10-cycle stall before word stall_w,
    // optional start pulse while busy before word restart_w. Called at a negedge.
    task automatic run_pass(input int d, input int stall_w, input int restart_w);
        int t;
        int e;
        logic ok;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        for (int w = 0; w < 4; w++) begin
            if (w == restart_w) begin
                start[d] = 1'b1;
                @(negedge clk);
                start[d] = 1'b0;
            end
            if (w == stall_w) begin
                t = 0;
                while (!in_ready[d] && t < LIM) begin @(negedge clk); t++; end
                chk("stall_reach_load", 64'(t < LIM), 64'd1);
                e  = edges_of(d);
                ok = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    if (scan_clk[d] !== 1'b0 || scan_en[d] !== 1'b1 || in_ready[d] !== 1'b1) ok = 1'b0;
                end
                chk("stall_lines", 64'(ok), 64'd1);
                chk("stall_no_edges", 64'(edges_of(d) - e), 64'd0);
            end
            in_valid[d] = 1'b1;
            in_data[d]  = words[w];
            t = 0;
            while (!in_ready[d] && t < LIM) begin @(negedge clk); t++; end
            chk("handshake_wait", 64'(t < LIM), 64'd1);
            @(negedge clk);
            in_valid[d] = 1'b0;
        end
        t = 0;
        while (!done[d] && t < LIM) begin @(negedge clk); t++; end
        chk("done_wait", 64'(t < LIM), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    int e0, h0, d0, r0, b0;
    int t;

    initial begin
        start    = '0;
        in_valid = '0;
        in_data  = '0;

        // 1: reset, and start ignored while reset is held
        repeat (3) @(negedge clk);
        chk("rst_outs_d1", 64'({busy[0], done[0], in_ready[0], scan_clk[0], scan_en[0],
                                scan_in[0], rb_valid[0], rb_data[0]}), 64'd0);
        chk("rst_outs_d3", 64'({busy[1], done[1], in_ready[1], scan_clk[1], scan_en[1],
                                scan_in[1], rb_valid[1], rb_data[1]}), 64'd0);
        start = 2'b11;
        @(negedge clk);
        start = 2'b00;
        @(negedge clk);
        chk("rst_start_ignored", 64'({busy, in_ready, scan_en}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 2: load pass, chain starts at zero
        e0 = edges0; h0 = hs0; d0 = dn0; r0 = rbn0; b0 = bc0;
        run_pass(0, -1, -1);
        chk("p2_edges", 64'(edges0 - e0), 64'd29);
        chk("p2_handshakes", 64'(hs0 - h0), 64'd4);
        chk("p2_done_count", 64'(dn0 - d0), 64'd1);
        chk("p2_busy_cycles", 64'(bc0 - b0), 64'd63);
        chk("p2_first_byte_bits", 64'(si0[42:35]), 64'hA5);
        chk("p2_last_word_bits", 64'(si0[63:59]), 64'h12);
        chk("p2_chain", 64'(chain0), 64'h12FF3CA5);
        chk("p2_rb_count", 64'(rbn0 - r0), 64'd4);
        chk("p2_rb_old_zero", 64'(rbl0), 64'd0);
        chk("p2_idle_after", 64'({busy[0], scan_en[0], scan_clk[0]}), 64'd0);

        // 3: readback of the previously loaded contents
        e0 = edges0; r0 = rbn0;
        run_pass(0, -1, -1);
        chk("p3_edges", 64'(edges0 - e0), 64'd29);
        chk("p3_rb_count", 64'(rbn0 - r0), 64'd4);
        chk("p3_rb_words", 64'(rbl0), 64'hA53CFF12);
        chk("p3_rb_hold", 64'(rb_data[0]), 64'h12);

        // 4: underrun before word 3
        e0 = edges0; h0 = hs0; d0 = dn0; b0 = bc0;
        run_pass(0, 2, -1);
        chk("p4_edges", 64'(edges0 - e0), 64'd29);
        chk("p4_handshakes", 64'(hs0 - h0), 64'd4);
        chk("p4_done_count", 64'(dn0 - d0), 64'd1);
        chk("p4_busy_cycles", 64'(bc0 - b0), 64'd73);
        chk("p4_stream", 64'(si0[63:35]), 64'h12FF3CA5);
        chk("p4_chain", 64'(chain0), 64'h12FF3CA5);
        chk("p4_rb_words", 64'(rbl0), 64'hA53CFF12);

        // 5: reset after the 10th rising edge, then a full restart
        e0 = edges0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = words[w];
            t = 0;
            while (!in_ready[0] && t < LIM) begin @(negedge clk); t++; end
            chk("p5_handshake_wait", 64'(t < LIM), 64'd1);
            @(negedge clk);
            in_valid[0] = 1'b0;
        end
        t = 0;
        while ((edges0 - e0) < 10 && t < LIM) begin @(negedge clk); t++; end
        chk("p5_reach_edge10", 64'(t < LIM), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("p5_reset_outs", 64'({scan_clk[0], scan_en[0], busy[0], in_ready[0], scan_in[0]}), 64'd0);
        repeat (5) @(negedge clk);
        chk("p5_no_more_edges", 64'(edges0 - e0), 64'd10);
        reset = 1'b0;
        @(negedge clk);
        e0 = edges0; d0 = dn0;
        run_pass(0, -1, -1);
        chk("p5_restart_edges", 64'(edges0 - e0), 64'd29);
        chk("p5_restart_done", 64'(dn0 - d0), 64'd1);
        chk("p5_restart_chain", 64'(chain0), 64'h12FF3CA5);

        // 6: DIV=3 with a start pulse while busy
        e0 = edges1; h0 = hs1; d0 = dn1; b0 = bc1;
        run_pass(1, -1, 2);
        chk("p6_edges", 64'(edges1 - e0), 64'd29);
        chk("p6_handshakes", 64'(hs1 - h0), 64'd4);
        chk("p6_high_min", 64'(hmin1), 64'd3);
        chk("p6_high_max", 64'(hmax1), 64'd3);
        chk("p6_low_min", 64'(lmin1), 64'd3);
        chk("p6_busy_cycles", 64'(bc1 - b0), 64'd179);
        chk("p6_chain", 64'(chain1), 64'h12FF3CA5);
        repeat (20) @(negedge clk);
        chk("p6_done_once", 64'(dn1 - d0), 64'd1);
        chk("p6_idle_after", 64'({busy[1], scan_en[1]}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
